// File: rtl/prog_loader_if.sv
// Stream-in and memory-write bundle between the boot loader and its environment.
// The loader sits on the slave side: it consumes the byte stream and drives the memory port.
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: takes a (length, payload, checksum) frame, writes the payload
// to main memory from address 0, and releases the CPU from reset only after a verified load.
module prog_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cpu_halt,
    prog_loader_if.slave bus,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RUN, ERROR} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH:0]   remaining, remaining_nx;
    logic [ADDR_WIDTH-1:0] addr, addr_nx;
    logic [DATA_WIDTH-1:0] sum, sum_nx;
    logic                  mem_we_nx;
    logic [ADDR_WIDTH-1:0] mem_addr_nx;
    logic [DATA_WIDTH-1:0] mem_data_nx;
    logic                  done_nx, error_nx, busy_nx;
    logic                  xfer;

    function automatic logic [DATA_WIDTH-1:0] csum_add(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        return a + b;
    endfunction

    assign xfer    = bus.in_valid & bus.in_ready;
    assign busy_nx = (state_nx == LEN) || (state_nx == DATA) || (state_nx == CSUM);

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        addr_nx      = addr;
        sum_nx       = sum;
        mem_we_nx    = 1'b0;
        mem_addr_nx  = bus.mem_addr;
        mem_data_nx  = bus.mem_data;
        done_nx      = done;
        error_nx     = error;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LEN;
                    done_nx  = 1'b0;
                    error_nx = 1'b0;
                end
            end
            LEN: begin
                if (xfer) begin
                    // A zero length byte stands for a full 2^ADDR_WIDTH image.
                    remaining_nx = (bus.in_data == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                                       : {1'b0, bus.in_data};
                    addr_nx      = '0;
                    sum_nx       = '0;
                    state_nx     = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    mem_we_nx    = 1'b1;
                    mem_addr_nx  = addr;
                    mem_data_nx  = bus.in_data;
                    sum_nx       = csum_add(sum, bus.in_data);
                    addr_nx      = addr + ADDR_WIDTH'(1);
                    remaining_nx = remaining - (ADDR_WIDTH+1)'(1);
                    if (remaining == (ADDR_WIDTH+1)'(1))
                        state_nx = CSUM;
                end
            end
            CSUM: begin
                if (xfer) begin
                    if (bus.in_data == sum) begin
                        state_nx = RUN;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = ERROR;
                        error_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                // A new load takes priority over a halt reclaim.
                if (start) begin
                    state_nx = LEN;
                    done_nx  = 1'b0;
                end else if (cpu_halt) begin
                    state_nx = IDLE;
                end
            end
            ERROR: begin
                if (start) begin
                    state_nx = LEN;
                    error_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Frame bookkeeping is always initialised in LEN before use, so it needs no reset.
    always_ff @(posedge clk) begin
        remaining <= remaining_nx;
        addr      <= addr_nx;
        sum       <= sum_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.in_ready <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_reset    <= 1'b1;
        end else begin
            bus.in_ready <= busy_nx;
            bus.mem_we   <= mem_we_nx;
            bus.mem_addr <= mem_addr_nx;
            bus.mem_data <= mem_data_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            error        <= error_nx;
            cpu_reset    <= (state_nx != RUN);
        end
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

- Boot-time program loader for the 8-bit multicycle CPU.
- Accepts a framed byte stream (length, payload, checksum) over a valid/ready interface.
- Writes the payload into the 256x8 main memory from address 0 and holds the CPU in reset until a load verifies.
- On a good checksum, releases the CPU. When the CPU asserts HALT, reclaims it by re-asserting CPU reset.

## Interface
Parameters:
- ADDR_WIDTH, 8, memory address width; must equal DATA_WIDTH (length byte encodes a full memory image).
- DATA_WIDTH, 8, memory/stream byte width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a load; sampled only in IDLE, RUN, ERROR.
- in_valid  in  1  stream byte present.
- in_data  in  DATA_WIDTH  stream byte.
- in_ready  out  1  loader accepts byte; transfer = in_valid & in_ready on a rising edge.
- cpu_halt  in  1  CPU halt output.
- cpu_reset  out  1  drives CPU synchronous reset; high = CPU held.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_data  out  DATA_WIDTH  memory write data.
- busy  out  1  load in progress (LEN, DATA, CSUM).
- done  out  1  last load verified.
- error  out  1  last load failed checksum.

## Operation
- States: IDLE, LEN, DATA, CSUM, RUN, ERROR. Reset state is IDLE.
- All outputs are registered. Reset values:
  - cpu_reset=1.
  - in_ready=0, mem_we=0, mem_addr=0, mem_data=0.
  - busy=0, done=0, error=0.
- IDLE: cpu_reset=1. start -> LEN; clear done and error.
- LEN: in_ready=1. On transfer:
  - remaining = (in_data==0) ? 2^ADDR_WIDTH : in_data. remaining is (ADDR_WIDTH+1)-bit.
  - addr=0, sum=0. Go to DATA.
- DATA: in_ready=1. On transfer:
  - mem_addr=addr, mem_data=in_data, mem_we=1 for exactly one cycle.
  - sum = sum + in_data, mod 2^DATA_WIDTH.
  - addr = addr + 1, wrapping 0xFF -> 0x00.
  - remaining = remaining - 1. When it reaches 0, go to CSUM.
- CSUM: in_ready=1. On transfer:
  - in_data==sum -> RUN, done=1.
  - otherwise -> ERROR, error=1.
- RUN: cpu_reset=0, done=1.
  - cpu_halt=1 -> IDLE, cpu_reset=1, done stays 1.
  - start (priority over cpu_halt) -> LEN, cpu_reset=1, done=0.
- ERROR: cpu_reset=1, error=1. start -> LEN, error=0.
- start in LEN/DATA/CSUM is ignored; no abort except reset.
- in_valid is ignored when in_ready=0. in_data is never consumed outside LEN/DATA/CSUM.
- Memory is written only in DATA. Bytes beyond the declared length are not consumed until the next load.
- Reset mid-load: returns to reset values next edge. Memory already written is left unchanged. cpu_reset stays 1.

## Timing
- start sampled at edge T: state=LEN, busy=1, in_ready=1 from T+1.
- Data byte accepted at edge T: mem_we=1 with that byte's addr/data during T+1 only.
- Back-to-back transfers are sustained at 1 byte/cycle, with no bubbles between LEN, DATA and CSUM.
- Checksum accepted at edge T: from T+1, in_ready=0, busy=0, and done or error set. On a match, cpu_reset=0 from T+1.
- Full load with in_valid held high: N+2 transfers in N+2 consecutive cycles. Last mem_we precedes cpu_reset deassertion by one cycle.
- cpu_halt sampled high in RUN at edge T: cpu_reset=1 from T+1.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1, start=1 -> all outputs at reset values, no mem_we pulse.
- Good load: start, then stream 0x03,0x61,0x02,0xE0,0x43 with in_valid held high -> writes (0,0x61),(1,0x02),(2,0xE0) on three consecutive cycles; next cycle done=1, cpu_reset=0, busy=0.
- Bad checksum: same stream ending 0x44 -> error=1, done=0, cpu_reset=1. Then start + correct stream -> error=0, done=1.
- Full image: length 0x00, then bytes 0x00..0xFF, checksum 0x80 -> 256 writes, addr 0x00..0xFF; done=1. Memory readback matches addr==data.
- Backpressure and halt: good load with in_valid low on alternate cycles -> identical writes, one per accepted byte. In RUN, pulse cpu_halt -> IDLE, cpu_reset=1, done stays 1.
- Reset mid-DATA: after 2 of 5 payload bytes, assert reset -> cpu_reset=1, busy=0, no further mem_we. Addresses 0-1 keep the written data.
